// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states, grant sides
// and default-width address/word typedefs.
package mem_arbiter_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   typedef logic [ADDR_W_DEF-1:0] addr_t;
   typedef logic [DATA_W_DEF-1:0] word_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DACC = 2'd1,
      IACC = 2'd2
   } arb_state_t;

   typedef enum logic {
      GNT_D = 1'b0,
      GNT_I = 1'b1
   } grant_t;

   function automatic logic is_access(arb_state_t s);
      return (s == DACC) || (s == IACC);
   endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Access watchdog: counts access cycles without ram_ready, pulses expire when
// the count reaches TIMEOUT and holds a sticky err until reset.
module mem_arb_watchdog #(
   parameter int TIMEOUT = 255
) (
   input  logic CLK,
   input  logic nRST,
   input  logic active,
   input  logic ready,
   output logic expire,
   output logic err
);

   // The counter only ever holds 0..TIMEOUT-1; the TIMEOUT-th stalled cycle expires.
   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   logic [CNT_W-1:0] count;

   assign expire = active && !ready && (count == CNT_W'(TIMEOUT - 1));

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         count <= '0;
      end else if (!active || ready || expire) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         err <= 1'b0;
      end else if (expire) begin
         err <= 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data memory ports onto one single-ported RAM.
// Define MEM_ARBITER_FAIR_EN for alternating grants when both sides are pending.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic [DATA_W-1:0] iload,
   output logic              ihit,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   output logic [DATA_W-1:0] dload,
   output logic              dhit,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [DATA_W-1:0] ramstore,
   input  logic [DATA_W-1:0] ramload,
   input  logic              ram_ready,
   output logic              err
);

   arb_state_t        state, state_next;
   logic              d_req;
   logic              grant_d, grant_i;
   logic              expire;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_data;
   logic              lat_write;

   assign d_req = dREN || dWEN;

`ifdef MEM_ARBITER_FAIR_EN
   grant_t last_grant;

   // With both sides pending, the side that lost the previous contest wins.
   assign grant_d = (state == IDLE) && d_req && (!iREN || (last_grant == GNT_I));
   assign grant_i = (state == IDLE) && iREN && (!d_req || (last_grant == GNT_D));

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         last_grant <= GNT_D;
      end else if (grant_d) begin
         last_grant <= GNT_D;
      end else if (grant_i) begin
         last_grant <= GNT_I;
      end
   end
`else
   assign grant_d = (state == IDLE) && d_req;
   assign grant_i = (state == IDLE) && iREN && !d_req;
`endif

   mem_arb_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .CLK    (CLK),
      .nRST   (nRST),
      .active (is_access(state)),
      .ready  (ram_ready),
      .expire (expire),
      .err    (err)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // The access latch freezes the request at grant time so a flush cannot cancel it.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         lat_addr  <= '0;
         lat_data  <= '0;
         lat_write <= 1'b0;
      end else if (grant_d) begin
         lat_addr  <= daddr;
         lat_data  <= dstore;
         lat_write <= dWEN;
      end else if (grant_i) begin
         lat_addr  <= iaddr;
         lat_data  <= '0;
         lat_write <= 1'b0;
      end
   end

   // NOTE: every output of this block gets a default first, so no path leaves a
   // signal unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (grant_d) begin
               state_next = DACC;
            end else if (grant_i) begin
               state_next = IACC;
            end
         end
         DACC, IACC: begin
            if (ram_ready || expire) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      dhit     = 1'b0;
      dload    = '0;
      ihit     = 1'b0;
      iload    = '0;
      unique case (state)
         DACC: begin
            ramREN  = !lat_write;
            ramWEN  = lat_write;
            ramaddr = lat_addr;
            if (lat_write) begin
               ramstore = lat_data;
            end
            if (ram_ready) begin
               dhit  = 1'b1;
               dload = ramload;
            end
         end
         IACC: begin
            ramREN  = 1'b1;
            ramaddr = lat_addr;
            if (ram_ready) begin
               ihit  = 1'b1;
               iload = ramload;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts grant order
// and read data; a monitor checks RAM-side signals and hits against the queue.
`timescale 1ns/1ps
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;

   logic          CLK = 1'b0;
   logic          nRST;
   logic          iREN, dREN, dWEN, ihit, dhit, ramREN, ramWEN, ram_ready, err;
   logic [AW-1:0] iaddr, daddr, ramaddr;
   logic [DW-1:0] iload, dload, dstore, ramstore, ramload;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dhit(dhit),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ram_ready(ram_ready), .err(err)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      bit          side_i;
      bit          write;
      logic [AW-1:0] addr;
      logic [DW-1:0] store;
      logic [DW-1:0] load;
   } txn_t;

   txn_t exp_q[$];
   txn_t mon_t;
   int   checks = 0;
   int   errors = 0;

   logic [DW-1:0] ram_mem   [logic [AW-1:0]];
   logic [DW-1:0] model_mem [logic [AW-1:0]];
   bit   model_last_i = 1'b0;
   bit   fair_mode    = 1'b0;

   bit   resp_en  = 1'b1;
   int   lat_cnt  = 0;
   int   lat_goal = 1;
   int   force_lat = 0;
   int   ren_cycles = 0, wen_cycles = 0, dhit_cycles = 0, ihit_cycles = 0;

   function automatic logic [DW-1:0] init_val(logic [AW-1:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // RAM responder: answers each access after lat_goal access cycles.
   always @(posedge CLK) begin
      #1;
      if (resp_en) begin
         ram_ready = 1'b0;
         if (!nRST) begin
            lat_cnt = 0;
         end else if (ramREN || ramWEN) begin
            lat_cnt++;
            if (lat_cnt >= lat_goal) begin
               if (ramWEN) ram_mem[ramaddr] = ramstore;
               else ramload = ram_mem.exists(ramaddr) ? ram_mem[ramaddr] : init_val(ramaddr);
               ram_ready = 1'b1;
               lat_cnt   = 0;
               lat_goal  = (force_lat != 0) ? force_lat : int'($urandom_range(1, 3));
            end
         end
      end
   end

   // Monitor: compares RAM-side signals and hits with the head of the expected queue.
   always @(negedge CLK) begin
      if (nRST) begin
         if (ramREN) ren_cycles++;
         if (ramWEN) wen_cycles++;
         if (dhit)   dhit_cycles++;
         if (ihit)   ihit_cycles++;
         check("hit_exclusive", 64'(ihit & dhit), 0);
         if ((ramREN || ramWEN) && exp_q.size() > 0) begin
            check("ram_addr", ramaddr, exp_q[0].addr);
            check("ram_wen", ramWEN, exp_q[0].write);
            check("ram_ren", ramREN, !exp_q[0].write);
            if (exp_q[0].write) check("ram_store", ramstore, exp_q[0].store);
         end
         if (dhit || ihit) begin
            if (exp_q.size() == 0) begin
               check("unexpected_hit", {ihit, dhit}, 0);
            end else begin
               mon_t = exp_q.pop_front();
               check("hit_side", ihit, mon_t.side_i);
               if (!mon_t.write) check("load_data", ihit ? iload : dload, mon_t.load);
            end
         end
      end
   end

   function automatic txn_t model_access(bit side_i, bit write, logic [AW-1:0] a, logic [DW-1:0] s);
      txn_t t;
      t.side_i = side_i;
      t.write  = write;
      t.addr   = a;
      t.store  = s;
      t.load   = model_mem.exists(a) ? model_mem[a] : init_val(a);
      if (write) model_mem[a] = s;
      return t;
   endfunction

   task automatic run_txn(bit d_on, bit i_on, bit dw, bit dboth, logic [AW-1:0] da,
                          logic [DW-1:0] ds, logic [AW-1:0] ia, bit flush);
      bit first_i;
      txn_t td, ti;
      first_i = d_on && i_on ? (fair_mode && !model_last_i) : !d_on;
      if (first_i) begin
         ti = model_access(1'b1, 1'b0, ia, '0);
         exp_q.push_back(ti);
         if (d_on) begin
            td = model_access(1'b0, dw, da, ds);
            exp_q.push_back(td);
         end
      end else begin
         td = model_access(1'b0, dw, da, ds);
         exp_q.push_back(td);
         if (i_on) begin
            ti = model_access(1'b1, 1'b0, ia, '0);
            exp_q.push_back(ti);
         end
      end
      model_last_i = (d_on && i_on) ? !first_i : first_i;
      dREN  = d_on && (!dw || dboth);
      dWEN  = d_on && dw;
      daddr = da;
      dstore = ds;
      iREN  = i_on;
      iaddr = ia;
      for (int c = 0; c < 100; c++) begin
         @(negedge CLK);
         if (flush && c == 0) begin
            dREN = 1'b0;
            dWEN = 1'b0;
         end
         if (dhit) begin
            dREN = 1'b0;
            dWEN = 1'b0;
         end
         if (ihit) iREN = 1'b0;
         if (exp_q.size() == 0) break;
      end
      check("txn_drained", exp_q.size(), 0);
      exp_q.delete();
      dREN = 1'b0;
      dWEN = 1'b0;
      iREN = 1'b0;
      repeat (2) @(negedge CLK);
   endtask

   task automatic random_txn();
      int mode;
      mode = int'($urandom_range(0, 2));
      run_txn(mode != 1, mode != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              AW'({$urandom_range(0, 15), 2'b00}), DW'($urandom),
              AW'({$urandom_range(0, 15), 2'b00}), (mode == 0) && ($urandom_range(0, 3) == 0));
   endtask

   initial begin
      int cnt;
`ifdef MEM_ARBITER_FAIR_EN
      fair_mode = 1'b1;
`endif
      nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
      iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
      #1;
      check("reset_ram_en", {ramREN, ramWEN}, 0);
      check("reset_hits", {ihit, dhit, err}, 0);
      check("reset_ram_bus", {ramaddr, ramstore}, 0);
      check("reset_loads", {iload, dload}, 0);
      repeat (2) @(negedge CLK);
      nRST = 1'b1;
      @(negedge CLK);

      // Single data read at 0x40, three-cycle RAM latency.
      ram_mem[32'h40] = 32'hDEAD_BEEF;
      model_mem[32'h40] = 32'hDEAD_BEEF;
      force_lat = 3; lat_goal = 3;
      ren_cycles = 0; dhit_cycles = 0; ihit_cycles = 0;
      run_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h40, '0, '0, 1'b0);
      check("read_ren_cycles", ren_cycles, 3);
      check("read_dhit_cycles", dhit_cycles, 1);
      check("read_no_ihit", ihit_cycles, 0);

      // Write dropped the cycle after grant still completes.
      force_lat = 2; lat_goal = 2;
      wen_cycles = 0; dhit_cycles = 0;
      run_txn(1'b1, 1'b0, 1'b1, 1'b0, 32'h80, 32'h1234, '0, 1'b1);
      check("flush_wen_cycles", wen_cycles, 2);
      check("flush_dhit_cycles", dhit_cycles, 1);
      check("flush_mem", ram_mem[32'h80], 32'h1234);
      force_lat = 0; lat_goal = 1;

      // Both sides requesting at once.
      ihit_cycles = 0; dhit_cycles = 0;
      run_txn(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, '0, 32'h20, 1'b0);
      check("both_dhit", dhit_cycles, 1);
      check("both_ihit", ihit_cycles, 1);

      for (int n = 0; n < 150; n++) random_txn();

      // Watchdog: RAM never answers an instruction fetch.
      resp_en = 1'b0; ram_ready = 1'b0;
      check("err_before_timeout", err, 0);
      iREN = 1'b1; iaddr = 32'h100;
      cnt = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge CLK);
         if (err) break;
         if (ramREN) cnt++;
      end
      iREN = 1'b0;
      model_last_i = 1'b1;
      check("timeout_cycles", cnt, TO);
      check("timeout_err", err, 1);
      check("timeout_idle", {ramREN, ramWEN}, 0);
      repeat (5) @(negedge CLK);
      check("err_sticky", err, 1);
      check("post_timeout_idle", {ramREN, ramWEN}, 0);

      // Asynchronous reset in the middle of a data access.
      dREN = 1'b1; daddr = 32'h44;
      @(negedge CLK);
      @(negedge CLK);
      check("pre_reset_access", ramREN, 1);
      #2 nRST = 1'b0;
      #1;
      check("reset_mid_en", {ramREN, ramWEN}, 0);
      check("reset_mid_hits", {ihit, dhit}, 0);
      check("reset_mid_err", err, 0);
      check("reset_mid_addr", ramaddr, 0);
      dREN = 1'b0;
      @(negedge CLK);
      nRST = 1'b1;
      model_last_i = 1'b0;
      @(negedge CLK);
      ram_ready = 1'b1;
      #1;
      check("late_ready_no_hit", {ihit, dhit}, 0);
      @(negedge CLK);
      ram_ready = 1'b0;
      check("late_ready_idle", {ramREN, ramWEN}, 0);
      resp_en = 1'b1;

      for (int n = 0; n < 30; n++) random_txn();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
